// File: rtl/ddram_responder.sv
// On-chip RAM model of the DDR3 Avalon-MM port: byte-enable writes, write/read bursts,
// fixed read latency, optional LFSR-driven BUSY stalls and a sticky protocol-error flag.
module ddram_responder #(
  parameter int          AW        = 10,
  parameter int          RD_LAT    = 4,
  parameter int          STALL_EN  = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  output logic        DDRAM_BUSY,
  input  logic [7:0]  DDRAM_BURSTCNT,
  input  logic [28:0] DDRAM_ADDR,
  input  logic        DDRAM_RD,
  input  logic        DDRAM_WE,
  input  logic [63:0] DDRAM_DIN,
  input  logic [7:0]  DDRAM_BE,
  output logic [63:0] DDRAM_DOUT,
  output logic        DDRAM_DOUT_READY,
  output logic        cmd_err,
  output logic [15:0] rd_beats
);

  localparam logic [AW-1:0] A_ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_DATA} state_t;

  state_t         state_q;
  logic [AW-1:0]  addr_q;
  logic [7:0]     rem_q;
  logic [3:0]     lat_q;
  logic [15:0]    lfsr_q;
  logic           busy_q;
  logic           ready_q;
  logic           err_q;
  logic [63:0]    dout_q;
  logic [15:0]    beats_q;

  logic [63:0]    mem [0:(1<<AW)-1];

  logic [15:0]    lfsr_d;
  logic           stall_d;
  logic [AW-1:0]  cmd_addr;
  logic [7:0]     bc_eff;
  logic           accept;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic           unused_addr;

  // BUSY is registered, so the stall value is taken from the LFSR state it advances into.
  generate
    if (STALL_EN != 0) begin : g_stall
      logic lfsr_fb;
      assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
      assign lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
      assign stall_d = (lfsr_d[1:0] == 2'b00);
    end else begin : g_nostall
      assign lfsr_d  = lfsr_q;
      assign stall_d = 1'b0;
    end
  endgenerate

  assign cmd_addr    = DDRAM_ADDR[AW-1:0];
  assign unused_addr = ^DDRAM_ADDR[28:AW];
  assign bc_eff      = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
  assign accept      = ~busy_q;
  assign wr_en       = ~reset & accept & DDRAM_WE &
                       ((state_q == IDLE) | (state_q == WR_BURST));
  assign wr_addr     = (state_q == WR_BURST) ? addr_q : cmd_addr;

  always_ff @(posedge DDRAM_CLK) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (DDRAM_BE[i]) mem[wr_addr][8*i +: 8] <= DDRAM_DIN[8*i +: 8];
      end
    end
  end

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= 8'd0;
      lat_q   <= 4'd0;
      lfsr_q  <= LFSR_SEED;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 64'd0;
      beats_q <= 16'd0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        IDLE: begin
          busy_q <= stall_d;
          if (accept && DDRAM_WE) begin
            if (DDRAM_RD) err_q <= 1'b1;
            if (bc_eff > 8'd1) begin
              state_q <= WR_BURST;
              addr_q  <= cmd_addr + A_ONE;
              rem_q   <= bc_eff - 8'd1;
            end
          end else if (accept && DDRAM_RD) begin
            state_q <= RD_WAIT;
            addr_q  <= cmd_addr;
            rem_q   <= bc_eff;
            lat_q   <= 4'(RD_LAT - 1);
            busy_q  <= 1'b1;
          end
        end
        WR_BURST: begin
          busy_q <= stall_d;
          if (accept) begin
            if (DDRAM_RD) err_q <= 1'b1;
            if (DDRAM_WE) begin
              addr_q <= addr_q + A_ONE;
              rem_q  <= rem_q - 8'd1;
              if (rem_q == 8'd1) state_q <= IDLE;
            end
          end
        end
        RD_WAIT: begin
          busy_q <= 1'b1;
          if (lat_q == 4'd0) begin
            state_q <= RD_DATA;
            ready_q <= 1'b1;
            dout_q  <= mem[addr_q];
            addr_q  <= addr_q + A_ONE;
            rem_q   <= rem_q - 8'd1;
            beats_q <= beats_q + 16'd1;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        RD_DATA: begin
          // rem_q counts beats still owed; the cycle after the last beat drops READY.
          if (rem_q != 8'd0) begin
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
            dout_q  <= mem[addr_q];
            addr_q  <= addr_q + A_ONE;
            rem_q   <= rem_q - 8'd1;
            beats_q <= beats_q + 16'd1;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= stall_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign DDRAM_BUSY       = busy_q;
  assign DDRAM_DOUT       = dout_q;
  assign DDRAM_DOUT_READY = ready_q;
  assign cmd_err          = err_q;
  assign rd_beats         = beats_q;

endmodule

// File: tb/tb_ddram_responder.sv
// Bench for ddram_responder: a stall-free and a stalling instance share one input bus,
// each tracked by a timeline model of its memory, read windows and stall sequence.
module tb_ddram_responder;

  localparam int AW    = 10;
  localparam int L     = 4;
  localparam int DEPTH = 1 << AW;
  localparam int MASK  = DEPTH - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic        rd = 1'b0;
  logic [28:0] addr = '0;
  logic [63:0] din = '0;
  logic [7:0]  be = '0;
  logic [7:0]  bc = '0;

  logic        busy  [2];
  logic        ready [2];
  logic        err   [2];
  logic [63:0] dout  [2];
  logic [15:0] beats [2];

  always #5 clk = ~clk;

  ddram_responder #(.AW(AW), .RD_LAT(L), .STALL_EN(0), .LFSR_SEED(16'hACE1)) u0 (
    .DDRAM_CLK(clk), .reset(reset), .DDRAM_BUSY(busy[0]), .DDRAM_BURSTCNT(bc),
    .DDRAM_ADDR(addr), .DDRAM_RD(rd), .DDRAM_WE(we), .DDRAM_DIN(din), .DDRAM_BE(be),
    .DDRAM_DOUT(dout[0]), .DDRAM_DOUT_READY(ready[0]), .cmd_err(err[0]), .rd_beats(beats[0]));

  ddram_responder #(.AW(AW), .RD_LAT(L), .STALL_EN(1), .LFSR_SEED(16'hACE1)) u1 (
    .DDRAM_CLK(clk), .reset(reset), .DDRAM_BUSY(busy[1]), .DDRAM_BURSTCNT(bc),
    .DDRAM_ADDR(addr), .DDRAM_RD(rd), .DDRAM_WE(we), .DDRAM_DIN(din), .DDRAM_BE(be),
    .DDRAM_DOUT(dout[1]), .DDRAM_DOUT_READY(ready[1]), .cmd_err(err[1]), .rd_beats(beats[1]));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit t6_on = 1'b0;
  int idle_n = 0;
  int busy_n = 0;

  // Model state per instance: memory with known-byte mask, current activity, read window.
  longint      cyc = 0;
  logic [63:0] mmem   [2][DEPTH];
  logic [7:0]  mknown [2][DEPTH];
  int          m_phase [2];
  int          m_waddr [2];
  int          m_wrem  [2];
  longint      m_rstart [2];
  int          m_rn     [2];
  logic [63:0] m_rdata [2][256];
  logic [7:0]  m_rmask [2][256];
  logic [15:0] m_lfsr  [2];
  logic        e_busy  [2];
  logic        e_ready [2];
  logic        e_err   [2];
  logic [63:0] e_dout  [2];
  logic [63:0] e_dmask [2];
  logic [15:0] e_beats [2];

  function automatic logic [15:0] lfsr_next(logic [15:0] l);
    logic [15:0] b;
    b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
    return (l >> 1) | (b << 15);
  endfunction

  function automatic logic [63:0] bmask(logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic model_write(input int k, input int a);
    for (int i = 0; i < 8; i++) begin
      if (be[i]) begin
        mmem[k][a][8*i +: 8] = din[8*i +: 8];
        mknown[k][a][i] = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0;
      m_lfsr[k]  = 16'hACE1;
      e_busy[k]  = 1'b0;
      e_ready[k] = 1'b0;
      e_err[k]   = 1'b0;
      e_dout[k]  = '0;
      e_dmask[k] = '1;
      e_beats[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    bit acc;
    bit stall;
    int n;
    int a;
    int j;
    acc = !e_busy[k];
    m_lfsr[k] = lfsr_next(m_lfsr[k]);
    stall = (k == 1) && ((m_lfsr[k] % 4) == 0);
    n = (bc == 8'd0) ? 1 : int'(bc);
    a = int'(addr) & MASK;
    case (m_phase[k])
      0: begin
        if (acc && we) begin
          model_write(k, a);
          if (rd) e_err[k] = 1'b1;
          if (n > 1) begin
            m_phase[k] = 1;
            m_waddr[k] = (a + 1) & MASK;
            m_wrem[k]  = n - 1;
          end
        end else if (acc && rd) begin
          for (int i = 0; i < n; i++) begin
            m_rdata[k][i] = mmem[k][(a + i) & MASK];
            m_rmask[k][i] = mknown[k][(a + i) & MASK];
          end
          m_rstart[k] = cyc + L;
          m_rn[k]     = n;
          m_phase[k]  = 2;
        end
      end
      1: begin
        if (acc) begin
          if (rd) e_err[k] = 1'b1;
          if (we) begin
            model_write(k, m_waddr[k]);
            m_waddr[k] = (m_waddr[k] + 1) & MASK;
            m_wrem[k]  = m_wrem[k] - 1;
            if (m_wrem[k] == 0) m_phase[k] = 0;
          end
        end
      end
      default: begin
        if (cyc == m_rstart[k] + m_rn[k]) m_phase[k] = 0;
      end
    endcase
    e_busy[k]  = (m_phase[k] == 2) ? 1'b1 : stall;
    e_ready[k] = (m_phase[k] == 2) && (cyc >= m_rstart[k]) && (cyc < m_rstart[k] + m_rn[k]);
    if (e_ready[k]) begin
      j = int'(cyc - m_rstart[k]);
      e_dout[k]  = m_rdata[k][j];
      e_dmask[k] = bmask(m_rmask[k][j]);
      e_beats[k] = e_beats[k] + 16'd1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_reset();
      end else begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) model_step(k);
      end
    end
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          cmp($sformatf("u%0d_busy c%0d", k, cyc), 64'(busy[k]), 64'(e_busy[k]));
          cmp($sformatf("u%0d_ready c%0d", k, cyc), 64'(ready[k]), 64'(e_ready[k]));
          cmp($sformatf("u%0d_dout c%0d", k, cyc), dout[k] & e_dmask[k], e_dout[k] & e_dmask[k]);
          cmp($sformatf("u%0d_err c%0d", k, cyc), 64'(err[k]), 64'(e_err[k]));
          cmp($sformatf("u%0d_beats c%0d", k, cyc), 64'(beats[k]), 64'(e_beats[k]));
        end
        if (t6_on && m_phase[1] == 0) begin
          idle_n++;
          if (busy[1]) busy_n++;
        end
      end
    end
  end

  task automatic drive(input logic w, input logic r, input int a, input logic [63:0] d,
                       input logic [7:0] b, input logic [7:0] c);
    we = w; rd = r; addr = 29'(a); din = d; be = b; bc = c;
  endtask

  task automatic idle_in();
    we = 1'b0; rd = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input int a, input logic [63:0] d, input logic [7:0] b);
    drive(1'b1, 1'b0, a, d, b, 8'd1);
    step();
    idle_in();
  endtask

  logic [63:0] cap [16];
  logic        busy_t [48];
  int          lat;
  int          nb;

  // Read on the stall-free instance; t counts cycles after the accept edge.
  task automatic read_u0(input int a, input int n);
    drive(1'b0, 1'b1, a, 64'd0, 8'd0, 8'(n));
    @(posedge clk);
    #1;
    idle_in();
    lat = -1;
    nb = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      busy_t[t] = busy[0];
      if (ready[0]) begin
        if (nb == 0) lat = t;
        if (nb < 16) cap[nb] = dout[0];
        nb++;
      end
    end
    step();
  endtask

  task automatic issue_u1(input logic w, input logic r, input int a, input logic [63:0] d,
                          input logic [7:0] b);
    bit done;
    logic bz;
    done = 1'b0;
    drive(w, r, a, d, b, 8'd1);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      bz = busy[1];
      @(posedge clk);
      if (!bz) done = 1'b1;
    end
    #1;
    idle_in();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL u1_accept_timeout addr=%0d", a);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b1;
    int ok;
    int cnt;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < DEPTH; a++) begin
        mknown[k][a] = 8'h00;
        mmem[k][a] = '0;
      end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    cmp("rst_busy", 64'(busy[0]), 64'd0);
    cmp("rst_ready", 64'(ready[0]), 64'd0);
    cmp("rst_dout", dout[0], 64'd0);
    cmp("rst_beats", 64'(beats[0]), 64'd0);
    step();

    // Single write then single read.
    wr0(5, 64'h1122334455667788, 8'hFF);
    read_u0(5, 1);
    cmp("t1_latency", 64'(lat), 64'd4);
    cmp("t1_nbeats", 64'(nb), 64'd1);
    cmp("t1_data", cap[0], 64'h1122334455667788);
    cmp("t1_rd_beats", 64'(beats[0]), 64'd1);
    cmp("t1_model_dout", e_dout[0], 64'h1122334455667788);

    // Byte-enable merge.
    wr0(9, 64'd0, 8'hFF);
    wr0(9, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0C);
    read_u0(9, 1);
    cmp("t2_merge", cap[0], 64'h0000_0000_FFFF_0000);

    // Write and read bursts crossing the top of memory.
    drive(1'b1, 1'b0, 1022, 64'd1, 8'hFF, 8'd4);
    step();
    drive(1'b1, 1'b0, 0, 64'd2, 8'hFF, 8'd0);
    step();
    din = 64'd3;
    step();
    din = 64'd4;
    step();
    idle_in();
    read_u0(1022, 4);
    cmp("t3_nbeats", 64'(nb), 64'd4);
    cmp("t3_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 4; i++) cmp($sformatf("t3_beat%0d", i), cap[i], 64'(i + 1));
    ok = 1;
    for (int t = 0; t <= 7; t++) if (busy_t[t] !== 1'b1) ok = 0;
    cmp("t3_busy_window", 64'(ok), 64'd1);
    cmp("t3_busy_after", 64'(busy_t[8]), 64'd0);

    // Conflicting commands.
    drive(1'b1, 1'b1, 20, 64'hA5A5_0000_1234_5678, 8'hFF, 8'd1);
    step();
    idle_in();
    cmp("t4_err_set", 64'(err[0]), 64'd1);
    read_u0(20, 1);
    cmp("t4_write_won", cap[0], 64'hA5A5_0000_1234_5678);
    cmp("t4_nbeats", 64'(nb), 64'd1);
    drive(1'b1, 1'b0, 30, 64'hAAAA_0000_0000_AAAA, 8'hFF, 8'd2);
    step();
    drive(1'b1, 1'b1, 100, 64'hBBBB_0000_0000_BBBB, 8'hFF, 8'd0);
    step();
    idle_in();
    repeat (12) step();
    cmp("t4_no_stray_read", 64'(beats[0]), 64'd7);
    read_u0(30, 2);
    cmp("t4_burst_b0", cap[0], 64'hAAAA_0000_0000_AAAA);
    cmp("t4_burst_b1", cap[1], 64'hBBBB_0000_0000_BBBB);
    cmp("t4_err_sticky", 64'(err[0]), 64'd1);
    cmp("t4_rd_beats", 64'(beats[0]), 64'd9);

    // Reset during the data phase of an 8-beat read.
    drive(1'b1, 1'b0, 200, 64'hC0DE_0000_0000_0000, 8'hFF, 8'd8);
    step();
    for (int j = 1; j < 8; j++) begin
      din = 64'hC0DE_0000_0000_0000 + 64'(j);
      step();
    end
    idle_in();
    drive(1'b0, 1'b1, 200, 64'd0, 8'd0, 8'd8);
    step();
    idle_in();
    repeat (5) step();
    cmp("t5_in_flight", 64'(ready[0]), 64'd1);
    reset = 1'b1;
    #1;
    cmp("t5_ready_async", 64'(ready[0]), 64'd0);
    cmp("t5_busy_async", 64'(busy[0]), 64'd0);
    cmp("t5_err_async", 64'(err[0]), 64'd0);
    cmp("t5_u1_outs_async", {61'd0, ready[1], busy[1], err[1]}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ready[0]) cnt++;
    end
    step();
    cmp("t5_no_beats_after", 64'(cnt), 64'd0);
    read_u0(200, 8);
    cmp("t5_nbeats", 64'(nb), 64'd8);
    for (int j = 0; j < 8; j++)
      cmp($sformatf("t5_kept%0d", j), cap[j], 64'hC0DE_0000_0000_0000 + 64'(j));

    // Random traffic paced by the stalling instance's BUSY.
    b1 = int'(beats[1]);
    t6_on = 1'b1;
    for (int a = 0; a < 64; a++)
      issue_u1(1'b1, 1'b0, a, {$urandom, $urandom}, 8'hFF);
    for (int i = 0; i < 200; i++) begin
      issue_u1(1'b1, 1'b0, int'($urandom_range(0, 63)), {$urandom, $urandom}, 8'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
    for (int i = 0; i < 200; i++) begin
      issue_u1(1'b0, 1'b1, int'($urandom_range(0, 63)), 64'd0, 8'd0);
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (20) step();
    t6_on = 1'b0;
    cmp("t6_u1_read_count", 64'(16'(int'(beats[1]) - b1)), 64'd200);
    checks++;
    if (!(idle_n > 100 && busy_n * 100 >= idle_n * 15 && busy_n * 100 <= idle_n * 35)) begin
      errors++;
      $display("FAIL t6_busy_ratio busy=%0d idle=%0d required 15..35 percent", busy_n, idle_n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
